// File: rtl/mmu_banked.sv
// Banked CPU-to-SDRAM address translator: one page register per address window,
// per-window write protection with a sticky fault, and a latched sdc_busy handshake.
module mmu_banked #(
    parameter int CPU_AW   = 16,
    parameter int WIN_BITS = 2,
    parameter int SDC_AW   = 25,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_do,
    input  logic              sdc_cmd_wr,
    input  logic              sdc_cs,
    input  logic              sdc_rd,
    input  logic              sdc_wr,
    output logic              cpu_wait,
    output logic              cpu_ack,
    output logic [7:0]        cpu_di,
    output logic              fault,
    output logic [SDC_AW-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data_in,
    input  logic [DATA_W-1:0] sdc_data_out,
    output logic              sdc_cs_reg,
    output logic              sdc_rd_reg,
    output logic              sdc_wr_reg,
    input  logic              sdc_busy
);
    localparam int NWIN   = 2**WIN_BITS;
    localparam int OFS_W  = CPU_AW - WIN_BITS;
    localparam int PAGE_W = SDC_AW - OFS_W;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    state_t state, state_n;

    logic [NWIN-1:0][PAGE_W-1:0] page;
    logic [NWIN-1:0]             wp;
    logic                        rd_p0;
    logic                        busy_p0;

    logic [WIN_BITS-1:0] tr_win;
    logic [WIN_BITS-1:0] reg_win;
    logic [1:0]          reg_byte;
    logic [SDC_AW-1:0]   tr_addr;
    logic [PAGE_W-1:0]   page_cur;
    logic [PAGE_W-1:0]   page_b0;
    logic [PAGE_W-1:0]   page_b1;
    logic                req, req_rd, req_wr, prot_hit;
    logic                accept, start_issue, fault_set, ack_n, issue_done, rd_done;
    logic                unused_hi;

    assign unused_hi = ^sdc_data_out[DATA_W-1:8];
    assign cpu_wait  = (state != ST_IDLE);

    // Byte-lane merges are written with masks so narrow page widths need no special casing
    always_comb begin
        tr_win   = cpu_addr[CPU_AW-1:OFS_W];
        tr_addr  = {page[tr_win], cpu_addr[OFS_W-1:0]};
        reg_byte = cpu_addr[1:0];
        reg_win  = cpu_addr[WIN_BITS+1:2];
        page_cur = page[reg_win];
        page_b0  = (page_cur & ~PAGE_W'(8'hFF)) | PAGE_W'(cpu_do);
        page_b1  = (page_cur & PAGE_W'(8'hFF)) | PAGE_W'({cpu_do, 8'h00});
    end

    always_comb begin
        req         = sdc_cs & (sdc_rd | sdc_wr);
        req_rd      = sdc_rd;
        req_wr      = sdc_wr & ~sdc_rd;
        prot_hit    = req_wr & wp[tr_win];
        state_n     = state;
        accept      = 1'b0;
        start_issue = 1'b0;
        fault_set   = 1'b0;
        ack_n       = 1'b0;
        issue_done  = 1'b0;
        rd_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (prot_hit) begin
                        fault_set = 1'b1;
                        ack_n     = 1'b1;
                    end else begin
                        start_issue = 1'b1;
                        state_n     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (busy_p0) begin
                    issue_done = 1'b1;
                    state_n    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!sdc_busy) begin
                    ack_n   = 1'b1;
                    rd_done = rd_p0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Control: busy is only captured while issuing, so a controller busy left over from IDLE is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack    <= 1'b0;
            fault      <= 1'b0;
            sdc_cs_reg <= 1'b0;
            sdc_rd_reg <= 1'b0;
            sdc_wr_reg <= 1'b0;
            rd_p0      <= 1'b0;
            busy_p0    <= 1'b0;
        end else begin
            cpu_ack <= ack_n;
            busy_p0 <= (state == ST_ISSUE) & ~busy_p0 & sdc_busy;
            if (fault_set) begin
                fault <= 1'b1;
            end else if (sdc_cmd_wr && reg_byte == 2'd3) begin
                fault <= 1'b0;
            end
            if (accept) begin
                rd_p0 <= req_rd;
            end
            if (start_issue) begin
                sdc_cs_reg <= 1'b1;
                sdc_rd_reg <= req_rd;
                sdc_wr_reg <= req_wr;
            end else if (issue_done) begin
                sdc_cs_reg <= 1'b0;
                sdc_rd_reg <= 1'b0;
                sdc_wr_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdc_addr    <= '0;
            sdc_data_in <= '0;
            cpu_di      <= '0;
        end else begin
            if (accept) begin
                sdc_addr    <= tr_addr;
                sdc_data_in <= DATA_W'(cpu_do);
            end
            if (rd_done) begin
                cpu_di <= sdc_data_out[7:0];
            end
        end
    end

    // Register writes are accepted in every state; in-flight requests already hold their address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page <= '0;
            wp   <= '0;
        end else if (sdc_cmd_wr) begin
            case (reg_byte)
                2'd0:    page[reg_win] <= page_b0;
                2'd1:    page[reg_win] <= page_b1;
                2'd2:    wp[reg_win]   <= cpu_do[0];
                default: ;
            endcase
        end
    end
endmodule
